// File: rtl/nfc_wb_slave.sv
// rtl/nfc_wb_slave.sv - Wishbone classic slave front-end of the NAND flash controller
module nfc_wb_slave #(
    parameter int DW         = 32,
    parameter int AW         = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          eng_cmd_valid,
    input  logic          eng_cmd_ready,
    output logic [7:0]    eng_opcode,
    output logic [31:0]   eng_addr,
    input  logic          eng_done,
    input  logic          eng_err,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [DW-1:0] tx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    input  logic [DW-1:0] rx_data,
    output logic          irq_o
);

    // Pointer width (at least one bit) and occupancy count width.
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [AW-1:0] A_CMD    = AW'(0);
    localparam logic [AW-1:0] A_ADDR   = AW'(1);
    localparam logic [AW-1:0] A_STATUS = AW'(2);
    localparam logic [AW-1:0] A_DATA   = AW'(3);
    localparam logic [AW-1:0] A_IRQ_EN = AW'(4);

    typedef enum logic {
        WB_IDLE,
        WB_ACK
    } wb_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_ISSUE,
        C_BUSY
    } cmd_state_t;

    wb_state_t     wb_state_q;
    logic [DW-1:0] wb_dat_q;
    logic [DW-1:0] rd_mux;

    cmd_state_t    cmd_state_q;
    logic          eng_cmd_valid_q;
    logic [7:0]    opcode_q;
    logic [31:0]   eng_addr_q;
    logic [31:0]   addr_q;

    // Sticky STATUS bits 5:1 held as [4:0]: done, err, cmd_ovr, tx_ovf, rx_unf.
    logic [4:0]    sticky_q;
    logic [4:0]    sticky_d;
    logic [4:0]    sticky_set;
    logic [4:0]    sticky_clr;
    logic [4:0]    irq_en_q;
    logic          irq_q;

    logic [DW-1:0] tx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wptr_q, tx_rptr_q;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [DW-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wptr_q, rx_rptr_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic          rx_ready_q;

    logic          req, wr, rd;
    logic          wr_cmd, wr_addr, wr_status, wr_data, wr_irq_en, rd_data;
    logic          busy, tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic          done_set, err_set, cmd_ovr_set, tx_ovf_set, rx_unf_set;
    logic [31:0]   status_w;

    // A new access is only recognised while no acknowledge is outstanding.
    assign req       = wb_cyc_i & wb_stb_i & (wb_state_q == WB_IDLE);
    assign wr        = req & wb_we_i;
    assign rd        = req & ~wb_we_i;
    assign wr_cmd    = wr & (wb_adr_i == A_CMD);
    assign wr_addr   = wr & (wb_adr_i == A_ADDR);
    assign wr_status = wr & (wb_adr_i == A_STATUS);
    assign wr_data   = wr & (wb_adr_i == A_DATA);
    assign wr_irq_en = wr & (wb_adr_i == A_IRQ_EN);
    assign rd_data   = rd & (wb_adr_i == A_DATA);

    assign busy     = (cmd_state_q != C_IDLE);
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
    assign tx_pop  = tx_ready & ~tx_empty;
    assign tx_push = wr_data & (~tx_full | tx_pop);
    assign rx_pop  = rd_data & ~rx_empty;
    assign rx_push = rx_valid & (~rx_full | rx_pop);

    assign done_set    = (cmd_state_q == C_BUSY) & eng_done;
    assign err_set     = done_set & eng_err;
    assign cmd_ovr_set = wr_cmd & busy;
    assign tx_ovf_set  = wr_data & tx_full & ~tx_pop;
    assign rx_unf_set  = rd_data & rx_empty;

    assign sticky_set = {rx_unf_set, tx_ovf_set, cmd_ovr_set, err_set, done_set};
    assign sticky_clr = wr_status ? wb_dat_i[5:1] : 5'b0;
    // A set event in the same cycle as a clear keeps the bit set.
    assign sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;

    assign status_w = {8'b0, 8'(rx_cnt_q), 8'(tx_cnt_q), rx_empty, tx_full, sticky_q, busy};

    // Read data selection, captured into wb_dat_o on the detect cycle.
    always_comb begin
        rd_mux = '0;
        case (wb_adr_i)
            A_CMD:    rd_mux = DW'(opcode_q);
            A_ADDR:   rd_mux = DW'(addr_q);
            A_STATUS: rd_mux = DW'(status_w);
            A_DATA:   rd_mux = rx_empty ? '0 : rx_mem[rx_rptr_q];
            A_IRQ_EN: rd_mux = DW'({irq_en_q, 1'b0});
            default:  rd_mux = '0;
        endcase
    end

    // Occupancy next-state for both FIFOs.
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CW'(1);
        if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + CW'(1);
        if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
    end

    // Bus handshake: ack exactly one cycle after each detected request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_state_q <= WB_IDLE;
            wb_dat_q   <= '0;
        end else if (req) begin
            wb_state_q <= WB_ACK;
            wb_dat_q   <= rd_mux;
        end else begin
            wb_state_q <= WB_IDLE;
        end
    end

    // Command FSM: offer the latched opcode/address to the engine, then wait for completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_state_q     <= C_IDLE;
            eng_cmd_valid_q <= 1'b0;
            opcode_q        <= '0;
            eng_addr_q      <= '0;
        end else begin
            case (cmd_state_q)
                C_IDLE: begin
                    if (wr_cmd) begin
                        opcode_q        <= wb_dat_i[7:0];
                        eng_addr_q      <= addr_q;
                        eng_cmd_valid_q <= 1'b1;
                        cmd_state_q     <= C_ISSUE;
                    end
                end
                C_ISSUE: begin
                    if (eng_cmd_ready) begin
                        eng_cmd_valid_q <= 1'b0;
                        cmd_state_q     <= C_BUSY;
                    end
                end
                C_BUSY: begin
                    if (eng_done) cmd_state_q <= C_IDLE;
                end
                default: begin
                    eng_cmd_valid_q <= 1'b0;
                    cmd_state_q     <= C_IDLE;
                end
            endcase
        end
    end

    // Host registers, sticky status and the registered interrupt.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            irq_en_q <= '0;
            sticky_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_addr)   addr_q   <= wb_dat_i[31:0];
            if (wr_irq_en) irq_en_q <= wb_dat_i[5:1];
            sticky_q <= sticky_d;
            irq_q    <= |(sticky_q & irq_en_q);
        end
    end

    // TX FIFO pointers and count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + PW'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PW'(1);
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // TX FIFO storage.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wptr_q] <= wb_dat_i;
    end

    // RX FIFO pointers, count and registered ready.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + PW'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PW'(1);
            rx_cnt_q   <= rx_cnt_d;
            rx_ready_q <= (rx_cnt_d != FULL_CNT);
        end
    end

    // RX FIFO storage.
    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wptr_q] <= rx_data;
    end

    assign wb_dat_o      = wb_dat_q;
    assign wb_ack_o      = (wb_state_q == WB_ACK);
    assign eng_cmd_valid = eng_cmd_valid_q;
    assign eng_opcode    = opcode_q;
    assign eng_addr      = eng_addr_q;
    assign tx_valid      = ~tx_empty;
    assign tx_data       = tx_empty ? '0 : tx_mem[tx_rptr_q];
    assign rx_ready      = rx_ready_q;
    assign irq_o         = irq_q;

endmodule
